dmem_wait_ctrl: RTL and testbench
=================================

Name: dmem_wait_ctrl

Overview:
- Parametrised data-memory block for the SoC data bus; successor to the fixed single-cycle RAM.
- Stores words in an internal synchronous array and models configurable read and write latency.
- Asserts `miss` to stall the processor pipeline for exactly the configured number of cycles.
- Adds byte-enable writes and an out-of-range error flag.

Parameters:
- DATA_WIDTH, 32, word width in bits; legal values are 32 or 64.
- ADDR_WIDTH, 32, byte-address width presented by the bus.
- DEPTH_LOG2, 10, log2 of the number of words stored.
- RD_LATENCY, 2, miss cycles per read; range 1..15.
- WR_LATENCY, 1, miss cycles per write; range 1..15.
- BE_WIDTH, DATA_WIDTH/8, derived; do not override.

Ports:
- Clk  in  1  system clock; all logic on the rising edge.
- Rst  in  1  synchronous, active-high reset.
- address  in  ADDR_WIDTH  byte address of the access.
- data_in  in  DATA_WIDTH  write data.
- be  in  BE_WIDTH  byte enables for writes; ignored on reads.
- rw  in  1  1 = read, 0 = write.
- en  in  1  access request.
- data_out  out  DATA_WIDTH  read data, registered.
- miss  out  1  stall; high while an accepted access is incomplete.
- err  out  1  one-cycle pulse for an out-of-range access.

Behaviour:
- Reset (Rst=1 at an edge):
  - state=IDLE, counter=0, data_out=0, err=0.
  - Array contents are NOT cleared.
  - miss=0 during and after the reset cycle.
- Word index = address[log2(BE_WIDTH) +: DEPTH_LOG2]; low log2(BE_WIDTH) bits are ignored (no misalignment trap).
- Out of range: any set bit in address above the index field.
- States: IDLE, WAIT, DONE.
- miss is combinational: miss = en & (state != DONE) & !Rst.
- IDLE, en=0: stay IDLE.
- IDLE, en=1: latch address, data_in, be, rw.
  - LAT = RD_LATENCY if rw else WR_LATENCY.
  - LAT=1: go DONE.
  - Otherwise: go WAIT with counter=LAT-1.
- WAIT:
  - en=0: abort; go IDLE, no write, err=0.
  - counter==1: go DONE; otherwise decrement.
- On entry to DONE, read: data_out <= array[index], or 0 if out of range.
- On entry to DONE, write: data_out holds its previous value.
- DONE (miss=0 for one cycle):
  - Write in range: commit the enabled bytes at the DONE edge.
  - Out of range: err=1 during DONE, write dropped.
  - Next state: IDLE.
- Result: exactly LAT miss cycles per access, then one miss-free completion cycle.
- Back-to-back: en held high after DONE is a new request. The next miss asserts the cycle after DONE. Minimum access period is LAT+1 cycles.
- Request fields are captured at acceptance. Changes to address/data during WAIT are ignored. The processor is required to hold them, but the block does not check.
- Read-after-write to the same word: the read returns the new data (the write commits before the read is accepted).
- data_out holds its value until the next read completes.
- Reset mid-WAIT or mid-DONE: the pending access is discarded; no partial write.
- Counter width is 4 bits; no wrap-around is possible within the legal latency range.

Test Plan:
- Rst held 3 cycles, then release, en=0 -> miss=0, data_out=0, err=0, state IDLE.
- Defaults; write addr 0x10, data 0xDEADBEEF, be=4'hF -> miss=1 for 1 cycle, then DONE. Read addr 0x10 -> miss=1 for exactly 2 cycles, data_out=0xDEADBEEF in the DONE cycle.
- Write addr 0x10, data 0x000000AA, be=4'b0001 over 0xDEADBEEF -> subsequent read returns 0xDEADBEAA.
- Read addr 0x1000 (index beyond 1024 words) -> err=1 for one cycle in DONE, data_out=0. Write to 0x1000 -> err=1, no array word changes.
- RD_LATENCY=4; drop en after 2 miss cycles of a read -> miss=0, state IDLE, data_out unchanged. Issue Rst during WAIT of a write -> the target word keeps its old value.
- Back-to-back reads to 0x0 then 0x4 with en held high -> miss pattern 1,1,0,1,1,0, with the correct data in each 0 cycle.

Source files
------------

// File: rtl/dmem_wait_ctrl.sv
// Data memory with configurable read/write wait states, byte-enable writes
// and an out-of-range error pulse; miss stalls the pipeline during the wait.
module dmem_wait_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int DEPTH_LOG2 = 10,
    parameter int RD_LATENCY = 2,
    parameter int WR_LATENCY = 1,
    parameter int BE_WIDTH   = DATA_WIDTH / 8
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [BE_WIDTH-1:0]   be,
    input  logic                  rw,
    input  logic                  en,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  miss,
    output logic                  err
);

    localparam int         OFF    = $clog2(BE_WIDTH);
    localparam int         TOP    = OFF + DEPTH_LOG2;
    localparam int         DEPTH  = 1 << DEPTH_LOG2;
    localparam logic [3:0] RD_LAT = 4'(RD_LATENCY);
    localparam logic [3:0] WR_LAT = 4'(WR_LATENCY);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t                  state, state_nxt;
    logic [3:0]              counter, counter_nxt;
    logic [3:0]              lat;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   data_q;
    logic [BE_WIDTH-1:0]     be_q;
    logic                    rw_q;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    logic [ADDR_WIDTH-1:0]   acc_addr;
    logic                    acc_rw;
    logic [DEPTH_LOG2-1:0]   acc_idx;
    logic                    acc_oor;
    logic                    entering_done;

    // Live inputs describe the request at acceptance; the captured copy afterwards.
    assign acc_addr      = (state == IDLE) ? address : addr_q;
    assign acc_rw        = (state == IDLE) ? rw : rw_q;
    assign acc_idx       = acc_addr[OFF +: DEPTH_LOG2];
    assign acc_oor       = (acc_addr >> TOP) != '0;
    assign entering_done = (state_nxt == DONE);
    assign lat           = rw ? RD_LAT : WR_LAT;

    assign miss = en & (state != DONE) & ~Rst;

    always_comb begin
        state_nxt   = state;
        counter_nxt = counter;
        case (state)
            IDLE: begin
                if (en) begin
                    if (lat == 4'd1) begin
                        state_nxt = DONE;
                    end else begin
                        state_nxt   = WAIT;
                        counter_nxt = lat - 4'd1;
                    end
                end
            end
            WAIT: begin
                if (!en) begin
                    state_nxt = IDLE;
                end else if (counter == 4'd1) begin
                    state_nxt = DONE;
                end else begin
                    counter_nxt = counter - 4'd1;
                end
            end
            DONE: begin
                state_nxt   = IDLE;
                counter_nxt = '0;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state    <= IDLE;
            counter  <= '0;
            data_out <= '0;
            err      <= 1'b0;
        end else begin
            state   <= state_nxt;
            counter <= counter_nxt;
            err     <= entering_done & acc_oor;
            if (entering_done && acc_rw) begin
                data_out <= acc_oor ? '0 : mem[acc_idx];
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (state == IDLE && en) begin
            addr_q <= address;
            data_q <= data_in;
            be_q   <= be;
            rw_q   <= rw;
        end
    end

    // Storage is never reset; a reset during DONE suppresses the pending write.
    always_ff @(posedge Clk) begin
        if (!Rst && state == DONE && !rw_q && !acc_oor) begin
            for (int unsigned b = 0; b < BE_WIDTH; b++) begin
                if (be_q[b]) begin
                    mem[acc_idx][b*8 +: 8] <= data_q[b*8 +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_wait_ctrl.sv
// Randomized bench for dmem_wait_ctrl: two instances (default latencies and a
// slower, smaller one) checked against a word-level reference model.
module tb_dmem_wait_ctrl;

    logic        clk;
    logic        rst  [2];
    logic [31:0] addr [2];
    logic [31:0] din  [2];
    logic [3:0]  be   [2];
    logic        rw   [2];
    logic        en   [2];
    logic [31:0] dout [2];
    logic        miss [2];
    logic        err  [2];

    dmem_wait_ctrl #(
        .DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH_LOG2(10),
        .RD_LATENCY(2), .WR_LATENCY(1)
    ) u_dut0 (
        .Clk(clk), .Rst(rst[0]), .address(addr[0]), .data_in(din[0]), .be(be[0]),
        .rw(rw[0]), .en(en[0]), .data_out(dout[0]), .miss(miss[0]), .err(err[0])
    );

    dmem_wait_ctrl #(
        .DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH_LOG2(4),
        .RD_LATENCY(4), .WR_LATENCY(3)
    ) u_dut1 (
        .Clk(clk), .Rst(rst[1]), .address(addr[1]), .data_in(din[1]), .be(be[1]),
        .rw(rw[1]), .en(en[1]), .data_out(dout[1]), .miss(miss[1]), .err(err[1])
    );

    int unsigned lat_rd [2] = '{2, 4};
    int unsigned lat_wr [2] = '{1, 3};
    int unsigned dl     [2] = '{10, 4};

    logic [31:0] mem_m   [2][8];
    logic [31:0] exp_dout[2];

    int n_tests = 0;
    int n_fail  = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int s, input int n);
        en[s] = 1'b0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            check_eq("idle_miss", miss[s], 1'b0);
            check_eq("idle_err", err[s], 1'b0);
            check_eq("idle_dout", dout[s], exp_dout[s]);
            next_cycle();
        end
    endtask

    task automatic access(input int s, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] b, input logic r);
        int unsigned lat;
        int unsigned idx;
        logic        oor;
        lat = r ? lat_rd[s] : lat_wr[s];
        oor = (a >> (2 + dl[s])) != 0;
        idx = (a >> 2) & ((32'd1 << dl[s]) - 1);
        addr[s] = a; din[s] = d; be[s] = b; rw[s] = r; en[s] = 1'b1;
        for (int unsigned k = 0; k < lat; k++) begin
            @(negedge clk);
            check_eq("miss_wait", miss[s], 1'b1);
            next_cycle();
            // fields must come from the captured copy, not the live bus
            addr[s] = $urandom; din[s] = $urandom; be[s] = 4'($urandom); rw[s] = 1'($urandom);
        end
        if (r) begin
            exp_dout[s] = oor ? 32'h0 : mem_m[s][idx];
        end else if (!oor && idx < 8) begin
            for (int i = 0; i < 4; i++)
                if (b[i]) mem_m[s][idx][i*8 +: 8] = d[i*8 +: 8];
        end
        @(negedge clk);
        check_eq("miss_done", miss[s], 1'b0);
        check_eq("err_done", err[s], oor);
        check_eq("dout_done", dout[s], exp_dout[s]);
        next_cycle();
    endtask

    task automatic abort(input int s, input logic [31:0] a, input logic r, input int n);
        addr[s] = a; din[s] = $urandom; be[s] = 4'hF; rw[s] = r; en[s] = 1'b1;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            check_eq("abort_miss", miss[s], 1'b1);
            next_cycle();
        end
        en[s] = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check_eq("abort_miss_off", miss[s], 1'b0);
            check_eq("abort_err", err[s], 1'b0);
            check_eq("abort_dout", dout[s], exp_dout[s]);
            next_cycle();
        end
    endtask

    task automatic rst_mid_write(input int s, input logic [31:0] a, input logic [31:0] d);
        addr[s] = a; din[s] = d; be[s] = 4'hF; rw[s] = 1'b0; en[s] = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check_eq("rstw_miss", miss[s], 1'b1);
            next_cycle();
        end
        rst[s] = 1'b1;
        @(negedge clk);
        check_eq("rstw_miss_in_rst", miss[s], 1'b0);
        next_cycle();
        rst[s] = 1'b0;
        en[s]  = 1'b0;
        exp_dout[s] = 32'h0;
        @(negedge clk);
        check_eq("rstw_dout", dout[s], 32'h0);
        check_eq("rstw_err", err[s], 1'b0);
        check_eq("rstw_miss", miss[s], 1'b0);
        next_cycle();
    endtask

    initial begin
        int          s;
        logic        r;
        logic [31:0] a;
        int unsigned lat;

        for (int i = 0; i < 2; i++) begin
            rst[i] = 1'b1; en[i] = 1'b1; addr[i] = '0; din[i] = '0; be[i] = '0; rw[i] = 1'b1;
        end
        #1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check_eq("rst_miss0", miss[0], 1'b0);
            check_eq("rst_miss1", miss[1], 1'b0);
            next_cycle();
        end
        for (int i = 0; i < 2; i++) begin
            rst[i] = 1'b0; en[i] = 1'b0; exp_dout[i] = 32'h0;
        end
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check_eq("post_rst_miss", miss[i], 1'b0);
            check_eq("post_rst_dout", dout[i], 32'h0);
            check_eq("post_rst_err", err[i], 1'b0);
        end
        next_cycle();

        for (int i = 0; i < 2; i++)
            for (int w = 0; w < 8; w++)
                access(i, 32'(w * 4), $urandom, 4'hF, 1'b0);
        idle(0, 1);

        access(0, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0);
        idle(0, 1);
        access(0, 32'h10, 32'h0, 4'h0, 1'b1);
        check_eq("dir_rd_deadbeef", exp_dout[0], 32'hDEADBEEF);
        idle(0, 1);
        access(0, 32'h10, 32'h000000AA, 4'b0001, 1'b0);
        access(0, 32'h10, 32'h0, 4'h0, 1'b1);
        check_eq("dir_rd_merged", exp_dout[0], 32'hDEADBEAA);
        idle(0, 1);
        access(0, 32'h1000, 32'h0, 4'h0, 1'b1);
        access(0, 32'h1000, 32'h12345678, 4'hF, 1'b0);
        access(0, 32'h0, 32'h0, 4'h0, 1'b1);
        idle(0, 2);
        access(0, 32'h0, 32'h0, 4'h0, 1'b1);
        access(0, 32'h4, 32'h0, 4'h0, 1'b1);
        idle(0, 1);

        abort(1, 32'h8, 1'b1, 2);
        access(1, 32'h8, 32'h0, 4'h0, 1'b1);
        idle(1, 1);
        rst_mid_write(1, 32'h14, 32'hCAFEF00D);
        access(1, 32'h14, 32'h0, 4'h0, 1'b1);
        idle(1, 1);

        for (int it = 0; it < 300; it++) begin
            s = int'($urandom_range(0, 1));
            r = 1'($urandom);
            if ($urandom_range(0, 9) == 0)
                a = $urandom | (32'h1 << $urandom_range(2 + dl[s], 31));
            else
                a = 32'($urandom_range(0, 7) * 4 + $urandom_range(0, 3));
            lat = r ? lat_rd[s] : lat_wr[s];
            if (lat > 1 && $urandom_range(0, 19) == 0)
                abort(s, a, r, int'($urandom_range(1, lat - 1)));
            else
                access(s, a, $urandom, 4'($urandom), r);
            idle(s, int'($urandom_range(0, 2)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
